// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: W-bit adder built from one 4-bit ripple slice reused per cycle.
// Ports: clk, rst_n (sync, active-low), start_valid/start_ready + a/b/cin in,
//   res_valid/res_ready + sum[W:0] out, busy; ovf with SERIAL_ADD_OVF_EN defined.
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [4*NIBBLES:0]   sum,
  output logic                 busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic                 ovf
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W:0]    r_sum;

  logic [IW+1:0] w_base;
  logic [3:0]    w_na;
  logic [3:0]    w_nb;
  logic [3:0]    w_s;
  logic          w_c1;
  logic          w_c2;
  logic          w_c3;
  logic          w_c4;
  logic          w_last;
  logic          w_accept;

  // bit offset of the active nibble
  assign w_base = {r_idx, 2'b00};
  assign w_na   = r_a[w_base +: 4];
  assign w_nb   = r_b[w_base +: 4];
  assign w_last = (r_idx == IW'(NIBBLES - 1));

  // the single 4-bit ripple-carry slice
  assign w_s[0] = w_na[0] ^ w_nb[0] ^ r_carry;
  assign w_c1   = (w_na[0] & w_nb[0])
                | (r_carry & (w_na[0] ^ w_nb[0]));
  assign w_s[1] = w_na[1] ^ w_nb[1] ^ w_c1;
  assign w_c2   = (w_na[1] & w_nb[1])
                | (w_c1 & (w_na[1] ^ w_nb[1]));
  assign w_s[2] = w_na[2] ^ w_nb[2] ^ w_c2;
  assign w_c3   = (w_na[2] & w_nb[2])
                | (w_c2 & (w_na[2] ^ w_nb[2]));
  assign w_s[3] = w_na[3] ^ w_nb[3] ^ w_c3;
  assign w_c4   = (w_na[3] & w_nb[3])
                | (w_c3 & (w_na[3] ^ w_nb[3]));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    start_ready = 1'b0;
    busy        = 1'b0;
    res_valid   = 1'b0;
    w_accept    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_idx   <= '0;
      // upper slices read as zero until computed
      r_sum   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= w_s;
      r_carry            <= w_c4;
      if (w_last) begin
        r_idx    <= '0;
        r_sum[W] <= w_c4;
`ifdef SERIAL_ADD_OVF_EN
        // carry into MSB xor carry out of MSB
        r_ovf    <= w_c3 ^ w_c4;
`endif
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign sum = r_sum;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: self-checking bench for serial_add_ctrl, NIBBLES=4.
// Vector table plus hand sequences; results checked through a queue.
module tb_serial_add_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W:0]   sum;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W:0]   s;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W:0] s;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  vec_t tbl[10];

  serial_add_ctrl #(.NIBBLES(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .busy        (busy)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [W:0] act, logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t model(logic [W-1:0] x, logic [W-1:0] y,
                                 logic c);
    exp_t e;
    e.s   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.ovf = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic push(logic [W:0] s, logic o);
    exp_t e;
    e.s   = s;
    e.ovf = o;
    q.push_back(e);
  endtask

  task automatic pop_check(string name);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: result %h with empty queue", name, sum);
    end else begin
      e = q.pop_front();
      chk(name, sum, e.s);
`ifdef SERIAL_ADD_OVF_EN
      chk({name, "_ovf"}, 17'(ovf), 17'(e.ovf));
`endif
    end
  endtask

  task automatic run_op(vec_t v, string name);
    int n;
    @(negedge clk);
    chk({name, "_start_ready"}, 17'(start_ready), 17'd1);
    start_valid = 1'b1;
    a   = v.a;
    b   = v.b;
    cin = v.cin;
    push(v.s, v.ovf);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = ~v.cin;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) chk({name, "_cleared"}, sum, 17'd0);
      if (n == 2) begin
        chk({name, "_busy"}, 17'(busy), 17'd1);
        chk({name, "_partial"}, sum, {13'd0, v.s[3:0]});
      end
    end while (!res_valid && n < 20);
    chk({name, "_latency"}, 17'(n), 17'(N + 1));
    pop_check({name, "_sum"});
    @(negedge clk);
    chk({name, "_idle_ready"}, 17'(start_ready), 17'd1);
    chk({name, "_idle_valid"}, 17'(res_valid), 17'd0);
  endtask

  initial begin
    int k;
    int acc2;
    int r1;
    int r2;
    int n;
    bit seen;
    exp_t e;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vc;

    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1'b0};
    tbl[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1};
    tbl[3] = '{16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 1'b1, 17'h00001, 1'b0};
    tbl[6] = '{16'h8000, 16'hFFFF, 1'b0, 17'h17FFF, 1'b1};
    for (int i = 7; i < 10; i++) begin
      va = 16'($urandom);
      vb = 16'($urandom);
      vc = 1'($urandom);
      e  = model(va, vb, vc);
      tbl[i] = '{va, vb, vc, e.s, e.ovf};
    end

    repeat (2) @(negedge clk);
    chk("rst_start_ready", 17'(start_ready), 17'd1);
    chk("rst_res_valid", 17'(res_valid), 17'd0);
    chk("rst_busy", 17'(busy), 17'd0);
    chk("rst_sum", sum, 17'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_op(tbl[i], $sformatf("vec%0d", i));

    // back-to-back: start_valid held high throughout
    @(negedge clk);
    start_valid = 1'b1;
    a   = 16'h1234;
    b   = 16'h4321;
    cin = 1'b0;
    push(17'h05555, 1'b0);
    push(17'h10000, 1'b1);
    @(posedge clk);
    #1;
    a = 16'h8000;
    b = 16'h8000;
    k = 0; acc2 = -1; r1 = -1; r2 = -1;
    while (k < 30 && r2 < 0) begin
      @(negedge clk);
      k++;
      if (res_valid && res_ready) begin
        pop_check("b2b_sum");
        if (r1 < 0) r1 = k;
        else        r2 = k;
      end
      if (start_valid && start_ready && acc2 < 0) begin
        acc2 = k;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        a = '0;
        b = '0;
      end
    end
    chk("b2b_first_done", 17'(r1), 17'd5);
    chk("b2b_second_accept", 17'(acc2), 17'd6);
    chk("b2b_second_done", 17'(r2), 17'd11);

    // result held while consumer stalls
    @(negedge clk);
    res_ready   = 1'b0;
    start_valid = 1'b1;
    a   = 16'h1357;
    b   = 16'h2468;
    cin = 1'b1;
    push(17'h037C0, 1'b0);
    @(posedge clk);
    #1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 20);
    chk("hold_latency", 17'(n), 17'(N + 1));
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid", 17'(res_valid), 17'd1);
      chk("hold_sum", sum, 17'h037C0);
      chk("hold_start_ready", 17'(start_ready), 17'd0);
      chk("hold_busy", 17'(busy), 17'd0);
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    pop_check("hold_final");
    @(negedge clk);
    chk("hold_release_ready", 17'(start_ready), 17'd1);
    chk("hold_release_valid", 17'(res_valid), 17'd0);

    // reset while idx=2
    @(negedge clk);
    start_valid = 1'b1;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy", 17'(busy), 17'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_start_ready", 17'(start_ready), 17'd1);
    chk("abort_sum", sum, 17'd0);
    chk("abort_res_valid", 17'(res_valid), 17'd0);
    chk("abort_busy_low", 17'(busy), 17'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (res_valid || busy) seen = 1'b1;
    end
    chk("abort_no_result", 17'(seen), 17'd0);

    run_op(tbl[1], "recover");

    chk("queue_empty", 17'(q.size()), 17'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
